// File: rtl/uart_frame_pkg.sv
// ----------------------------------------------------------------------------
// uart_frame_pkg
// Shared definitions for the compressed-frame UART link. Both the receiver
// (uart_frame_receiver) and the transmit-side frame_end_stuffer import it.
//   - Receive state encoding (IDLE, START, DATA, STOP, WAIT_IDLE)
//   - Default end-of-frame delimiter (JPEG EOI marker, sent MSB byte first)
// No ports: package only.
// ----------------------------------------------------------------------------
package uart_frame_pkg;

    // Receive state machine encoding; kept as plain constants so older
    // tooling and the stuffer's debug taps can share the same values.
    typedef logic [2:0] rx_state_t;

    localparam rx_state_t RX_IDLE      = 3'd0;
    localparam rx_state_t RX_START     = 3'd1;
    localparam rx_state_t RX_DATA      = 3'd2;
    localparam rx_state_t RX_STOP      = 3'd3;
    localparam rx_state_t RX_WAIT_IDLE = 3'd4;

    // Default delimiter: JPEG end-of-image marker.
    localparam int unsigned DEFAULT_DELIMITER_LENGTH = 16;
    localparam logic [15:0] DEFAULT_DELIMITER        = 16'hffd9;

    // Number of whole bytes in a delimiter of the given bit length.
    function automatic int unsigned delimiter_bytes(input int unsigned length_bits);
        return length_bits / 32'd8;
    endfunction

endpackage

// File: rtl/uart_frame_receiver_byte_rx.sv
// ----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 byte deserialiser: two-flop synchroniser on the serial line, a bit
// timer that samples mid-bit, and the receive state machine.
// Ports:
//   clock      in   system clock
//   nreset     in   asynchronous active-low reset
//   uart_rx    in   serial line, idle high, asynchronous to clock
//   rx_byte    out  assembled byte (valid while byte_done is high)
//   byte_done  out  high for the single cycle in which a good stop bit is sampled
//   frame_err  out  high for the single cycle in which a low stop bit is sampled
// byte_done / frame_err are decoded purely from registers, so the parent can
// register them once and present the byte the cycle after the stop sample.
// ----------------------------------------------------------------------------
module uart_byte_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 4
)
(
    input  logic       clock,
    input  logic       nreset,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(CLOCKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLOCKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [TW-1:0] TIMER_ZERO = TW'(0);

    logic            rx_meta_r;
    logic            rx_s;          // synchronised serial line
    rx_state_t       state_r;
    rx_state_t       state_nxt_s;
    logic [TW-1:0]   timer_r;
    logic [TW-1:0]   timer_nxt_s;
    logic [2:0]      bit_idx_r;
    logic [2:0]      bit_idx_nxt_s;
    logic [7:0]      shift_r;
    logic [7:0]      shift_nxt_s;
    logic            timer_done_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_s      <= rx_meta_r;
        end
    end

    assign timer_done_s = (timer_r == TIMER_ZERO);

    // Next-state logic: the timer is reloaded on each sample so bits are
    // taken every CLOCKS_PER_BIT cycles, starting half a bit after the edge.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        case (state_r)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_nxt_s = RX_START;
                    timer_nxt_s = HALF_LOAD;
                end else begin
                    state_nxt_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (!timer_done_s) begin
                    timer_nxt_s = timer_r - TIMER_ONE;
                end else if (rx_s) begin
                    // Line back high at mid start bit: a glitch, not a byte.
                    state_nxt_s = RX_IDLE;
                end else begin
                    state_nxt_s   = RX_DATA;
                    bit_idx_nxt_s = 3'd0;
                    timer_nxt_s   = FULL_LOAD;
                end
            end
            RX_DATA: begin
                if (!timer_done_s) begin
                    timer_nxt_s = timer_r - TIMER_ONE;
                end else begin
                    // LSB arrives first, so shift in from the top.
                    shift_nxt_s = {rx_s, shift_r[7:1]};
                    timer_nxt_s = FULL_LOAD;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = RX_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (!timer_done_s) begin
                    timer_nxt_s = timer_r - TIMER_ONE;
                end else if (rx_s) begin
                    state_nxt_s = RX_IDLE;
                end else begin
                    // Hold off until the line returns high so a break does
                    // not look like an endless stream of start bits.
                    state_nxt_s = RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s) begin
                    state_nxt_s = RX_IDLE;
                end else begin
                    state_nxt_s = RX_WAIT_IDLE;
                end
            end
            default: begin
                state_nxt_s = RX_IDLE;
            end
        endcase
    end

    // State, timer and shift register update.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r   <= RX_IDLE;
            timer_r   <= TIMER_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    assign rx_byte   = shift_r;
    assign byte_done = (state_r == RX_STOP) && timer_done_s && rx_s;
    assign frame_err = (state_r == RX_STOP) && timer_done_s && !rx_s;

endmodule

// File: rtl/uart_frame_receiver.sv
// ----------------------------------------------------------------------------
// uart_frame_receiver
// Receive end of the compressed-frame UART link. Deserialises 8N1 bytes,
// detects the end-of-frame delimiter and reports frame boundaries and length.
// Optional build macro: UART_FRAME_RX_STRIP_EN -- when defined, delimiter
// bytes are removed from the output stream (output lags by
// DELIMITER_LENGTH/8-1 bytes) and frame_length excludes the delimiter.
// Ports:
//   clock           in   system clock
//   nreset          in   asynchronous active-low reset
//   uart_rx         in   serial input, idle high, asynchronous
//   data_out        out  received byte
//   data_out_valid  out  one-cycle strobe qualifying data_out
//   frame_end       out  one-cycle strobe on the final delimiter byte
//   frame_length    out  byte count of the last frame, held until next frame_end
//   framing_error   out  one-cycle strobe when a stop bit is sampled low
// ----------------------------------------------------------------------------
module uart_frame_receiver
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT   = 4,
    parameter int unsigned DELIMITER_LENGTH = DEFAULT_DELIMITER_LENGTH,
    parameter logic [DELIMITER_LENGTH-1:0] DELIMITER = DEFAULT_DELIMITER,
    parameter int unsigned COUNT_WIDTH      = 24
)
(
    input  logic                   clock,
    input  logic                   nreset,
    input  logic                   uart_rx,
    output logic [7:0]             data_out,
    output logic                   data_out_valid,
    output logic                   frame_end,
    output logic [COUNT_WIDTH-1:0] frame_length,
    output logic                   framing_error
);

    localparam int unsigned NB = delimiter_bytes(DELIMITER_LENGTH);
    localparam int unsigned FW = $clog2(NB + 1);
    // Only the older NB-1 bytes need storing; the newest is the incoming byte.
    localparam int unsigned HW = (NB > 1) ? (NB - 1) * 8 : 8;
    localparam logic [FW-1:0] FULL_FILL = FW'(NB);
    localparam logic [FW-1:0] FILL_ONE  = FW'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    logic [7:0]                  rx_byte_s;
    logic                        byte_done_s;
    logic                        frame_err_s;
    logic [HW-1:0]               held_r;
    logic [HW-1:0]               held_nxt_s;
    logic [FW-1:0]               fill_r;
    logic [FW-1:0]               fill_inc_s;
    logic [DELIMITER_LENGTH-1:0] win_shift_s;
    logic                        match_s;
    logic [COUNT_WIDTH-1:0]      count_r;
    logic [COUNT_WIDTH-1:0]      count_inc_s;
    logic                        emit_s;
    logic [7:0]                  emit_byte_s;
    logic [COUNT_WIDTH-1:0]      match_len_s;

    uart_byte_rx #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_byte_rx (
        .clock     (clock),
        .nreset    (nreset),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte_s),
        .byte_done (byte_done_s),
        .frame_err (frame_err_s)
    );

    // Window as it would look with the incoming byte shifted in (newest in LSBs).
    generate
        if (NB > 1) begin : g_multi_byte
            assign win_shift_s = {held_r, rx_byte_s};
            assign held_nxt_s  = win_shift_s[HW-1:0];
        end else begin : g_single_byte
            assign win_shift_s = rx_byte_s;
            assign held_nxt_s  = {HW{1'b0}};
        end
    endgenerate

    // Saturating increments for the window fill count and the byte counter.
    always_comb begin
        if (fill_r == FULL_FILL) begin
            fill_inc_s = fill_r;
        end else begin
            fill_inc_s = fill_r + FILL_ONE;
        end
        if (&count_r) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + COUNT_ONE;
        end
    end

    assign match_s = byte_done_s && (fill_inc_s == FULL_FILL) && (win_shift_s == DELIMITER);

`ifdef UART_FRAME_RX_STRIP_EN
    logic [7:0] oldest_s;

    // Oldest held byte: released once a newer non-matching byte arrives.
    generate
        if (NB > 1) begin : g_oldest_multi
            assign oldest_s = held_r[HW-1 -: 8];
        end else begin : g_oldest_single
            assign oldest_s = rx_byte_s;
        end
    endgenerate

    // A byte is only released when NB-1 newer bytes sit behind it, which
    // guarantees it can never turn out to be part of a delimiter.
    assign emit_s      = byte_done_s && !match_s && (fill_r >= FW'(NB - 1));
    assign emit_byte_s = oldest_s;
    assign match_len_s = count_r;
`else
    assign emit_s      = byte_done_s;
    assign emit_byte_s = rx_byte_s;
    assign match_len_s = count_inc_s;
`endif

    // Delimiter match window; cleared after a match (no shared bytes between
    // matches) and on a framing error (held bytes are flushed, not emitted).
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            held_r <= {HW{1'b0}};
            fill_r <= {FW{1'b0}};
        end else if (frame_err_s || match_s) begin
            held_r <= {HW{1'b0}};
            fill_r <= {FW{1'b0}};
        end else if (byte_done_s) begin
            held_r <= held_nxt_s;
            fill_r <= fill_inc_s;
        end else begin
            held_r <= held_r;
            fill_r <= fill_r;
        end
    end

    // Per-frame byte counter and the latched length of the last frame.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            count_r      <= {COUNT_WIDTH{1'b0}};
            frame_length <= {COUNT_WIDTH{1'b0}};
        end else if (match_s) begin
            count_r      <= {COUNT_WIDTH{1'b0}};
            frame_length <= match_len_s;
        end else if (emit_s) begin
            count_r      <= count_inc_s;
            frame_length <= frame_length;
        end else begin
            count_r      <= count_r;
            frame_length <= frame_length;
        end
    end

    // Registered output strobes and data.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            frame_end      <= 1'b0;
            framing_error  <= 1'b0;
        end else begin
            data_out_valid <= emit_s;
            frame_end      <= match_s;
            framing_error  <= frame_err_s;
            if (emit_s) begin
                data_out <= emit_byte_s;
            end else begin
                data_out <= data_out;
            end
        end
    end

endmodule
